pattern_shifter: RTL
====================

PATTERN_SHIFTER -- requirements
Module: pattern_shifter

Interface
REQ-001 SHALL have parameter C_NUM_ROWS, default 160, number of sensor pixel rows per subframe.
REQ-002 SHALL have parameter C_WORDS_PER_ROW, default 18, number of 10-bit pattern words per row.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port subc_start  input  1  one-cycle request to load one subframe of patterns.
REQ-006 SHALL have port FIFO_empty  input  1  pattern FIFO empty flag.
REQ-007 SHALL have port Pat_in  input  10  pattern FIFO read data, valid one cycle after FIFO_rd.
REQ-008 SHALL have port FIFO_rd  output  1  pattern FIFO read enable.
REQ-009 SHALL have port pat_data  output  10  pattern word presented to the sensor shift-in.
REQ-010 SHALL have port pat_valid  output  1  pat_data valid; sensor shifts on this cycle.
REQ-011 SHALL have port row_addr  output  8  row being loaded.
REQ-012 SHALL have port row_load  output  1  one-cycle strobe latching the shifted row into row_addr.
REQ-013 SHALL have port busy  output  1  high from accepted subc_start until subc_done.
REQ-014 SHALL have port subc_done  output  1  one-cycle pulse after the last row_load.

Function
REQ-015 SHALL implement states S_idle, S_shift, S_rowld, S_done, one-hot encoded; any illegal encoding SHALL return to S_idle next cycle.
REQ-016 In S_idle, subc_start SHALL clear word and row counters, set busy, enter S_shift; subc_start in any other state SHALL be ignored.
REQ-017 In S_shift, FIFO_rd SHALL be asserted in a cycle only if FIFO_empty is low and fewer than C_WORDS_PER_ROW reads have been issued for the current row.
REQ-018 The cycle after each FIFO_rd, pat_data SHALL equal Pat_in and pat_valid SHALL be 1; otherwise pat_valid SHALL be 0 and pat_data SHALL hold its last value.
REQ-019 When FIFO_empty is high, reading SHALL stall with no FIFO_rd and no pat_valid; no word SHALL be dropped or duplicated.
REQ-020 After the C_WORDS_PER_ROW-th pat_valid of a row, the FSM SHALL enter S_rowld; row_load SHALL pulse exactly one cycle with row_addr equal to the current row index.
REQ-021 From S_rowld, if row index < C_NUM_ROWS-1, the row index SHALL increment, the word counter SHALL clear, and the FSM SHALL return to S_shift; otherwise it SHALL enter S_done.
REQ-022 In S_done, subc_done SHALL pulse one cycle, busy SHALL fall, and the FSM SHALL return to S_idle.
REQ-023 Total per subframe SHALL be exactly C_NUM_ROWS*C_WORDS_PER_ROW FIFO_rd pulses and C_NUM_ROWS row_load pulses; row_addr SHALL never exceed C_NUM_ROWS-1.
REQ-024 With a never-empty FIFO, throughput SHALL be one word per cycle within a row, plus one S_rowld cycle per row.

Reset
REQ-025 rst SHALL force S_idle and clear counters within one cycle, including mid-subframe; FIFO_rd, pat_valid, row_load, busy, subc_done SHALL be 0, pat_data and row_addr SHALL be 0.
REQ-026 A read issued in the cycle rst asserts SHALL NOT produce pat_valid.

Configuration
REQ-027 With macro PAT_UNDERFLOW_CNT_EN defined, SHALL add output underflow_cnt [15:0]: counts S_shift cycles stalled by FIFO_empty, saturating at 16'hFFFF, cleared by rst and by accepted subc_start.
REQ-028 Without PAT_UNDERFLOW_CNT_EN, port underflow_cnt and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-029 Full FIFO, subc_start -> 2880 FIFO_rd, 2880 pat_valid, 160 row_load with row_addr 0..159, subc_done 2880+160+1 cycles after start region.
REQ-030 Ramp data 0,1,2,... -> pat_data sequence identical and in order; row_load after words 17, 35, ... 2879.
REQ-031 FIFO_empty forced high 5 cycles mid-row 3 -> no FIFO_rd/pat_valid those cycles, no lost word, underflow_cnt = 5 when macro defined.
REQ-032 subc_start pulsed while busy at row 50 -> ignored; single subc_done, counts unchanged.
REQ-033 rst asserted at row 80 word 7 -> next cycle all outputs 0, S_idle; fresh subc_start then completes full 160-row subframe.

Source files
------------

// File: rtl/pattern_shifter.sv
// pattern_shifter: pulls 10-bit pattern words from a FIFO and shifts them
// into the sensor row by row. Each row takes C_WORDS_PER_ROW words, then
// gets one row_load strobe. After C_NUM_ROWS rows it gives one subc_done.
//
// Optional build feature: define PAT_UNDERFLOW_CNT_EN to add the
// underflow_cnt output. It counts the shift cycles lost to an empty FIFO.
module pattern_shifter #(
  parameter int C_NUM_ROWS      = 160,
  parameter int C_WORDS_PER_ROW = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        subc_start,
  input  logic        FIFO_empty,
  input  logic [9:0]  Pat_in,
  output logic        FIFO_rd,
  output logic [9:0]  pat_data,
  output logic        pat_valid,
  output logic [7:0]  row_addr,
  output logic        row_load,
  output logic        busy,
  output logic        subc_done
`ifdef PAT_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int WCW = $clog2(C_WORDS_PER_ROW + 1);
  localparam logic [WCW-1:0] WORDS     = WCW'(C_WORDS_PER_ROW);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(C_WORDS_PER_ROW - 1);
  localparam logic [7:0]     LAST_ROW  = 8'(C_NUM_ROWS - 1);

  typedef enum logic [3:0] {
    S_idle  = 4'b0001,
    S_shift = 4'b0010,
    S_rowld = 4'b0100,
    S_done  = 4'b1000
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] word_q, word_d;
  logic [7:0]     row_q, row_d;
  logic           pat_valid_q;
  logic [9:0]     pat_hold_q;

  // State and counter registers. Reset returns to idle with counters cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_idle;
      word_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic and strobes. The last read of a row moves the FSM
  // straight to S_rowld, so the row's final word and row_load share a
  // cycle. This gives one word per cycle plus one load cycle per row.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    row_d     = row_q;
    FIFO_rd   = 1'b0;
    row_load  = 1'b0;
    busy      = 1'b0;
    subc_done = 1'b0;
    case (state_q)
      S_idle: begin
        if (subc_start) begin
          word_d  = '0;
          row_d   = '0;
          state_d = S_shift;
        end
      end
      S_shift: begin
        busy = 1'b1;
        if (!FIFO_empty && (word_q < WORDS)) begin
          FIFO_rd = 1'b1;
          word_d  = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            state_d = S_rowld;
          end
        end
      end
      S_rowld: begin
        busy     = 1'b1;
        row_load = 1'b1;
        if (row_q != LAST_ROW) begin
          row_d   = row_q + 8'd1;
          word_d  = '0;
          state_d = S_shift;
        end else begin
          state_d = S_done;
        end
      end
      S_done: begin
        subc_done = 1'b1;
        state_d   = S_idle;
      end
      default: begin
        word_d  = '0;
        row_d   = '0;
        state_d = S_idle;
      end
    endcase
  end

  // FIFO data arrives one cycle after FIFO_rd. Here it is marked valid and
  // also captured, so pat_data keeps its value between valid words.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_valid_q <= 1'b0;
      pat_hold_q  <= '0;
    end else begin
      pat_valid_q <= FIFO_rd;
      pat_hold_q  <= pat_data;
    end
  end

  assign pat_valid = pat_valid_q;
  assign pat_data  = pat_valid_q ? Pat_in : pat_hold_q;
  assign row_addr  = row_q;

`ifdef PAT_UNDERFLOW_CNT_EN
  logic [15:0] uf_q;
  logic        start_ok;
  logic        stall;

  assign start_ok = (state_q == S_idle) && subc_start;
  assign stall    = (state_q == S_shift) && FIFO_empty && (word_q < WORDS);

  // Saturating count of shift cycles that stalled on an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      uf_q <= '0;
    end else if (stall && (uf_q != '1)) begin
      uf_q <= uf_q + 16'd1;
    end
  end

  assign underflow_cnt = uf_q;
`endif

endmodule
